instruction_cache: RTL and testbench

INSTRUCTION_CACHE -- requirements
Module: instruction_cache

---
 rtl/instruction_cache.sv | 111 +++++++++++
 tb/tb_instruction_cache.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_cache.sv
// Direct-mapped 8-line instruction cache with 16-byte blocks, fetched as whole blocks
// from instruction memory on a miss. Saturating hit/miss counters for profiling.
module instruction_cache (
    input  logic         clock,
    input  logic         reset,
    input  logic         read,
    input  logic [9:0]   address,
    output logic [31:0]  instruction,
    output logic         busywait,
    output logic         mem_read,
    output logic [5:0]   mem_address,
    input  logic [127:0] mem_readinst,
    input  logic         mem_busywait,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
);

    typedef enum logic [1:0] {
        StIdle,
        StMemRead,
        StUpdate
    } state_e;

    state_e       state_q;
    logic [7:0]   valid_q;
    logic [2:0]   tag_q  [8];
    logic [127:0] data_q [8];

    logic [2:0] addr_tag;
    logic [2:0] addr_index;
    logic [1:0] addr_offset;
    logic       hit;
    logic       unused_byte_sel;

    assign addr_tag        = address[9:7];
    assign addr_index      = address[6:4];
    assign addr_offset     = address[3:2];
    assign unused_byte_sel = ^address[1:0];

    assign hit = valid_q[addr_index] && (tag_q[addr_index] == addr_tag);

    always_comb begin
        instruction = '0;
        case (addr_offset)
            2'd0:    instruction = data_q[addr_index][31:0];
            2'd1:    instruction = data_q[addr_index][63:32];
            2'd2:    instruction = data_q[addr_index][95:64];
            default: instruction = data_q[addr_index][127:96];
        endcase
    end

    always_comb begin
        busywait = 1'b1;
        if (state_q == StIdle) begin
            busywait = read && !hit;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            valid_q     <= '0;
            mem_read    <= 1'b0;
            mem_address <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (read) begin
                        if (hit) begin
                            if (hit_count != 16'hFFFF) begin
                                hit_count <= hit_count + 16'd1;
                            end
                        end else begin
                            state_q     <= StMemRead;
                            mem_read    <= 1'b1;
                            mem_address <= address[9:4];
                            if (miss_count != 16'hFFFF) begin
                                miss_count <= miss_count + 16'd1;
                            end
                        end
                    end
                end
                StMemRead: begin
                    // Fill continues even if read drops; address is held by the CPU.
                    if (!mem_busywait) begin
                        state_q  <= StUpdate;
                        mem_read <= 1'b0;
                    end
                end
                StUpdate: begin
                    valid_q[addr_index] <= 1'b1;
                    state_q             <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Tag/data need no reset; an asserted reset forces IDLE, so no write can follow it.
    always_ff @(posedge clock) begin
        if (state_q == StUpdate) begin
            tag_q[addr_index]  <= addr_tag;
            data_q[addr_index] <= mem_readinst;
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Randomized scoreboard bench for instruction_cache: a memory model returns synthetic
// blocks, and a reference cache model predicts instruction, stall length and counters.
module tb_instruction_cache;

    logic         clock = 1'b0;
    logic         rst_n;
    logic         read;
    logic [9:0]   address;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readinst;
    logic         mem_busywait;
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;

    instruction_cache dut (
        .clock        (clock),
        .reset        (rst_n),
        .read         (read),
        .address      (address),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readinst (mem_readinst),
        .mem_busywait (mem_busywait),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        int          stall;
        logic [9:0]  addr;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         mem_lat = 5;
    logic [5:0] last_mem_addr;
    bit         ref_valid [8];
    logic [2:0] ref_tag   [8];
    int         ref_hits = 0;
    int         ref_misses = 0;
    int         mon_stall = 0;
    exp_t       mon_e;

    function automatic logic [31:0] blk_word(input logic [5:0] b, input logic [1:0] w);
        return 32'(b) * 32'h9E3779B1 + 32'(w) * 32'h7F4A7C15 + 32'h0BADF00D;
    endfunction

    function automatic logic [127:0] blk(input logic [5:0] b);
        return {blk_word(b, 2'd3), blk_word(b, 2'd2), blk_word(b, 2'd1), blk_word(b, 2'd0)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic check_counters();
        check("hit_count", 32'(hit_count), 32'(ref_hits));
        check("miss_count", 32'(miss_count), 32'(ref_misses));
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
        ref_hits   = 0;
        ref_misses = 0;
    endtask

    // Issue one fetch at posedge+1 and hold it until it resolves plus one hit cycle.
    task automatic fetch(input logic [9:0] a);
        logic [2:0] idx;
        logic [2:0] tag;
        bit         hit;
        exp_t       e;
        int         n;
        idx = a[6:4];
        tag = a[9:7];
        hit = ref_valid[idx] && (ref_tag[idx] == tag);
        e.instr = blk_word(a[9:4], a[3:2]);
        e.stall = hit ? 0 : mem_lat + 3;
        e.addr  = a;
        exp_q.push_back(e);
        if (!hit) begin
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tag;
            if (ref_misses < 65535) ref_misses++;
        end
        if (ref_hits < 65535) ref_hits++;
        address = a;
        read    = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (busywait !== 1'b0 && n < 64);
        if (busywait !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: address %h still busy after %0d cycles", a, n);
        end
        @(posedge clock);
        #1;
        read = 1'b0;
    endtask

    // Memory model: busy for mem_lat cycles after a request, then presents the block.
    initial begin
        mem_busywait  = 1'b1;
        mem_readinst  = '0;
        last_mem_addr = '0;
        forever begin
            @(posedge clock);
            #1;
            if (rst_n === 1'b1 && mem_read === 1'b1) begin
                last_mem_addr = mem_address;
                repeat (mem_lat) @(posedge clock);
                #1;
                mem_readinst = blk(last_mem_addr);
                mem_busywait = 1'b0;
                @(posedge clock);
                #1;
                mem_busywait = 1'b1;
            end
        end
    end

    // Monitor: every resolved fetch pops one expectation.
    initial begin
        forever begin
            @(negedge clock);
            if (rst_n !== 1'b1) begin
                mon_stall = 0;
            end else if (read === 1'b1) begin
                if (busywait !== 1'b0) begin
                    mon_stall++;
                end else begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_fetch: address %h with no expectation", address);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("instruction", instruction, mon_e.instr);
                        check("stall_cycles", 32'(mon_stall), 32'(mon_e.stall));
                    end
                    mon_stall = 0;
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] a;
        rst_n   = 1'b0;
        read    = 1'b0;
        address = '0;
        ref_reset();
        repeat (3) @(posedge clock);
        #1;
        check("reset_busywait", 32'(busywait), 32'd0);
        check("reset_mem_read", 32'(mem_read), 32'd0);
        check("reset_mem_address", 32'(mem_address), 32'd0);
        check_counters();
        rst_n = 1'b1;
        @(posedge clock);
        #1;

        // Cold fetch of 0x000 with a 5-cycle memory.
        mem_lat = 5;
        fork
            fetch(10'h000);
            begin
                @(negedge clock);
                check("cold_busywait", 32'(busywait), 32'd1);
                @(negedge clock);
                check("cold_mem_read", 32'(mem_read), 32'd1);
                check("cold_mem_address", 32'(mem_address), 32'd0);
            end
        join
        check("cold_miss_count", 32'(miss_count), 32'd1);
        check_counters();

        // Sequential hits within block 0.
        for (int i = 1; i < 4; i++) begin
            fetch(10'(i * 4));
            check("seq_mem_read", 32'(mem_read), 32'd0);
            check_counters();
        end

        // Conflict on index 0.
        mem_lat = 3;
        fetch(10'h080);
        check("conflict_mem_address", 32'(last_mem_addr), 32'h08);
        check_counters();
        fetch(10'h000);
        check_counters();

        // Idle cycles leave everything untouched.
        for (int i = 0; i < 8; i++) begin
            address = 10'($urandom);
            read    = 1'b0;
            @(negedge clock);
            check("idle_busywait", 32'(busywait), 32'd0);
            check("idle_mem_read", 32'(mem_read), 32'd0);
            @(posedge clock);
            #1;
        end
        check_counters();

        // Random fetches over tags 0..3 so hits and conflict misses both occur.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                address = 10'($urandom);
                @(posedge clock);
                #1;
            end
            mem_lat = $urandom_range(1, 6);
            a = {3'($urandom_range(0, 3)), 3'($urandom), 2'($urandom), 2'($urandom)};
            fetch(a);
            check_counters();
        end

        // Reset in the middle of a fill.
        mem_lat = 5;
        address = 10'h3F0;
        read    = 1'b1;
        @(negedge clock);
        check("midfill_busywait", 32'(busywait), 32'd1);
        @(negedge clock);
        check("midfill_mem_read", 32'(mem_read), 32'd1);
        check("midfill_mem_address", 32'(mem_address), 32'h3F);
        #2;
        rst_n = 1'b0;
        #1;
        read = 1'b0;
        ref_reset();
        check("midfill_reset_mem_read", 32'(mem_read), 32'd0);
        check("midfill_reset_mem_address", 32'(mem_address), 32'd0);
        check_counters();
        @(negedge clock);
        #3;
        rst_n = 1'b1;
        repeat (12) @(posedge clock);
        #1;
        mem_lat = 2;
        fetch(10'h3F0);
        check("refetch_miss_count", 32'(miss_count), 32'd1);
        check_counters();

        // Saturation of the hit counter.
        for (int i = 0; i < 70000; i++) begin
            fetch(10'h3F4);
        end
        check("hit_saturated", 32'(hit_count), 32'h0000FFFF);
        check_counters();

        repeat (5) @(posedge clock);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending_expectations: %0d left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
